sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the 8-bit × 16 sample-buffer FIFO.
- Sits between the sensor/ADC capture logic and the UART/readout path.
- Generalises width and depth, uses all DEPTH entries, supports simultaneous read/write, and reports occupancy, programmable watermarks and sticky overflow/underflow errors.
- Single clock domain.

Parameters:
- DATA_WIDTH, 8: bits per entry.
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= AEMPTY_THRESH.

Ports:
- sys_clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request; one entry per cycle while high, level-sensitive, no pulse mode.
- wr_data  in  DATA_WIDTH  write data, sampled when wr_en is high.
- rd_en  in  1  read request; one entry per cycle while high.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds newly popped data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  clears overflow/underflow.

Behaviour:
- Reset (sys_clock edge with reset=1):
  - Pointers, count, rd_data and rd_valid go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data and wins over any wr_en/rd_en in the same cycle.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the extra MSB distinguishes full from empty.
  - Memory is indexed by the low ADDR_WIDTH bits.
  - Pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated on pre-edge state:
  - wr_accept = wr_en & (~full | rd_en).
  - rd_accept = rd_en & ~empty.
- Write: on wr_accept, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read (default build):
  - On rd_accept, rd_data <= mem[rd_ptr], rd_ptr increments, rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Latency: data is on rd_data one cycle after the rd_en edge.
- Count update:
  - Increment on wr_accept only.
  - Decrement on rd_accept only.
  - Unchanged when both or neither occur.
- Boundary cases:
  - Full with wr_en and rd_en both high: both accepted, count stays DEPTH, full stays 1. Read returns the oldest entry, never the one being written.
  - Empty with wr_en and rd_en both high: write accepted, read rejected (underflow set), count becomes 1. No write-through.
  - Full with wr_en and rd_en low: write dropped, overflow <= 1, memory and pointers unchanged.
  - Empty with rd_en: underflow <= 1, rd_valid = 0, rd_data holds.
- Flag timing:
  - empty, full, almost_* and count are registered or derived from registered pointers.
  - All valid the cycle after the causing edge; no combinational path from wr_en/rd_en to any flag.
- err_clr:
  - Clears both sticky flags.
  - If a new error occurs in the same cycle as err_clr, set takes priority.
- Write-side behaviour is identical in both builds.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data always presents mem[rd_ptr], the head entry.
  - rd_valid = ~empty.
  - rd_en pops the head; the next entry appears the cycle after.
  - A write into an empty FIFO is visible on rd_data one cycle after the write edge.
  - Accept and underflow rules are unchanged.
- Undefined: standard 1-cycle read latency as in Behaviour.

Test Plan:
- Reset, then write 0x01..0x10 with DEPTH=16: full=1 and count=16 after the 16th edge; almost_full rises at count 14. A 17th write of 0xAA sets overflow=1 and count stays 16.
- From full, assert rd_en for 16 cycles: rd_data sequence is 0x01..0x10 with rd_valid=1 each cycle after request. Then empty=1, almost_empty=1 at count<=2. A 17th rd_en sets underflow=1 and rd_data stays 0x10.
- Full FIFO, simultaneous wr_en(0x55)+rd_en for 1 cycle: rd_data=0x01, count stays 16, no overflow. After draining, 0x55 is the last entry out.
- Empty FIFO, simultaneous wr_en(0x33)+rd_en: count=1, underflow=1, rd_valid=0. The next rd_en returns 0x33.
- Push and pop 40 entries at steady occupancy 3 to exercise pointer wrap: output order equals input order and count stays 3. Assert reset mid-stream: count=0, empty=1, rd_valid=0 next cycle. err_clr clears the sticky flags.
- With SYNC_FIFO_FWFT_EN: write 0x7E into an empty FIFO → rd_valid=1 and rd_data=0x7E one cycle later with no rd_en. A pop makes empty=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, watermarks and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one cycle of latency.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] ZERO_LVL   = '0;
    localparam logic [ADDR_WIDTH:0] ONE_LVL    = PW'(1);
    localparam logic [ADDR_WIDTH:0] FULL_LVL   = PW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = PW'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags come only from the registered count, so wr_en/rd_en never reach them combinationally.
    assign empty        = (count == ZERO_LVL);
    assign full         = (count == FULL_LVL);
    assign almost_full  = (count >= AFULL_LVL);
    assign almost_empty = (count <= AEMPTY_LVL);

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign wr_accept = wr_en & (~full | rd_en);
    assign rd_accept = rd_en & ~empty;

    always_ff @(posedge sys_clock) begin
        if (!reset && wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ONE_LVL;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ONE_LVL;
            end
            if (wr_accept && !rd_accept) begin
                count <= count + ONE_LVL;
            end else if (rd_accept && !wr_accept) begin
                count <= count - ONE_LVL;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_accept) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_accept) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_valid = ~empty;
`else
    // The head is read before any same-edge write lands, so a full read-while-write returns the oldest entry.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_accept) begin
            rd_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (default build, DEPTH=16).
module tb_sync_fifo_param;

    logic       sys_clock;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int pass_count = 0;
    int check_count = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic applyStimulus();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    initial begin
        logic [7:0] exp_head;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; err_clr = 1'b0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_aempty", almost_empty, 1);
        checkOutput("rst_afull", almost_full, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_underflow", underflow, 0);

        $display("[TB] fill 0x01..0x10");
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            applyStimulus();
            checkOutput("fill_count", count, i);
            checkOutput("fill_afull", almost_full, (i >= 14));
            checkOutput("fill_aempty", almost_empty, (i <= 2));
            checkOutput("fill_full", full, (i == 16));
            checkOutput("fill_empty", empty, 0);
        end
        wr_data = 8'hAA;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", count, 16);
        checkOutput("ovf_full", full, 1);

        $display("[TB] drain 16");
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            applyStimulus();
            checkOutput("drain_data", rd_data, i);
            checkOutput("drain_valid", rd_valid, 1);
            checkOutput("drain_count", count, 16 - i);
            checkOutput("drain_empty", empty, (i == 16));
            checkOutput("drain_aempty", almost_empty, ((16 - i) <= 2));
        end
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("udf_flag", underflow, 1);
        checkOutput("udf_rd_data_hold", rd_data, 8'h10);
        checkOutput("udf_rd_valid", rd_valid, 0);
        checkOutput("udf_ovf_sticky", overflow, 1);

        err_clr = 1'b1;
        applyStimulus();
        err_clr = 1'b0;
        checkOutput("clr_overflow", overflow, 0);
        checkOutput("clr_underflow", underflow, 0);

        $display("[TB] full read+write");
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            applyStimulus();
        end
        checkOutput("refill_full", full, 1);
        wr_data = 8'h55; rd_en = 1'b1;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("fullrw_data", rd_data, 8'h01);
        checkOutput("fullrw_valid", rd_valid, 1);
        checkOutput("fullrw_count", count, 16);
        checkOutput("fullrw_full", full, 1);
        checkOutput("fullrw_overflow", overflow, 0);
        for (int i = 2; i <= 16; i++) begin
            applyStimulus();
            checkOutput("fullrw_drain", rd_data, i);
        end
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("fullrw_last", rd_data, 8'h55);
        checkOutput("fullrw_last_empty", empty, 1);

        $display("[TB] empty read+write");
        wr_en = 1'b1; wr_data = 8'h33; rd_en = 1'b1;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("emptyrw_count", count, 1);
        checkOutput("emptyrw_underflow", underflow, 1);
        checkOutput("emptyrw_valid", rd_valid, 0);
        checkOutput("emptyrw_hold", rd_data, 8'h55);
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("emptyrw_next", rd_data, 8'h33);
        checkOutput("emptyrw_next_valid", rd_valid, 1);
        checkOutput("emptyrw_next_count", count, 0);

        rd_en = 1'b1; err_clr = 1'b1;
        applyStimulus();
        rd_en = 1'b0;
        checkOutput("clr_set_priority", underflow, 1);
        applyStimulus();
        err_clr = 1'b0;
        checkOutput("clr_after", underflow, 0);

        $display("[TB] steady occupancy wrap");
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
            applyStimulus();
        end
        checkOutput("wrap_prefill", count, 3);
        exp_head = 8'hA0;
        for (int k = 0; k < 40; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'hA3 + k);
            applyStimulus();
            checkOutput("wrap_data", rd_data, exp_head);
            checkOutput("wrap_count", count, 3);
            exp_head = exp_head + 8'h01;
        end
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_empty", empty, 1);
        checkOutput("midrst_valid", rd_valid, 0);
        checkOutput("midrst_rd_data", rd_data, 0);
        applyStimulus();
        checkOutput("midrst_idle_count", count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
